// File: rtl/onewire_rom_reader_if.sv
// Request/result bundle between a 1-Wire ROM reader and its user.
// master: user side, drives go. slave: reader side, returns busy/done/error/err_code/result.
interface onewire_rom_reader_if;
    logic        go;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [63:0] result;

    modport master (
        output go,
        input  busy, done, error, err_code, result
    );

    modport slave (
        input  go,
        output busy, done, error, err_code, result
    );
endinterface

// File: rtl/onewire_rom_reader.sv
// 1-Wire master that reads a 64-bit ROM ID with READ ROM (0x33), with retry,
// bus-stuck detection and optional CRC8 check (enable with ONEWIRE_CRC_CHECK_EN).
// Ports: clk, reset (sync, active-high), dq_in (async pad level), dq_oe (1 = pull low),
//        bus (slave modport: go in; busy/done/error/err_code/result out).
module onewire_rom_reader #(
    parameter int CLK_MHZ     = 100,
    parameter int T_RSTL_US   = 480,
    parameter int T_RSTH_US   = 480,
    parameter int T_PDMAX_US  = 240,
    parameter int T_SLOT_US   = 70,
    parameter int T_LOW0_US   = 60,
    parameter int T_LOW1_US   = 6,
    parameter int T_RDSAMP_US = 12,
    parameter int T_REC_US    = 10,
    parameter int N_RETRY     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic dq_in,
    output logic dq_oe,
    onewire_rom_reader_if.slave bus
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int SLOT_LEN = T_SLOT_US + T_REC_US;
    localparam int MAXP = max2(max2(max2(T_RSTL_US, T_RSTH_US),
                                    max2(T_PDMAX_US, SLOT_LEN)),
                               max2(max2(T_LOW0_US, T_LOW1_US), T_RDSAMP_US));
    localparam int US_W = $clog2(MAXP + 1);
    localparam int PW   = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int AW   = (N_RETRY > 0) ? $clog2(N_RETRY + 1) : 1;

    localparam logic [7:0]      ROM_CMD = 8'h33;
    localparam logic [US_W-1:0] PD_MIN  = US_W'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_HIGH,
        S_CMD,
        S_READ,
        S_CHECK,
        S_FAIL
    } state_t;

    state_t          state;
    logic [PW-1:0]   pre;
    logic            tick;
    logic            timed;
    logic [US_W-1:0] us_cnt;
    logic [US_W-1:0] us_nxt;
    logic [US_W-1:0] slot_low;
    logic            slot_end;
    logic [5:0]      bit_cnt;
    logic [AW-1:0]   attempt;
    logic            presence;
    logic [1:0]      fail_code;
    logic [63:0]     shreg;
    logic            dq_m;
    logic            dq_s;
    logic            dq_oe_r;
    logic            busy_r;
    logic            done_r;
    logic            error_r;
    logic [1:0]      err_code_r;
    logic [63:0]     result_r;

`ifdef ONEWIRE_CRC_CHECK_EN
    logic [7:0]      crc;
    logic            crc_fb;
    logic [7:0]      crc_nxt;

    // Dallas/Maxim CRC8, reflected form of x^8+x^5+x^4+1
    assign crc_fb  = crc[0] ^ dq_s;
    assign crc_nxt = {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
`endif

    assign timed = (state == S_RST_LOW) || (state == S_RST_HIGH) ||
                   (state == S_CMD) || (state == S_READ);

    assign tick     = (pre == PW'(CLK_MHZ - 1));
    assign us_nxt   = us_cnt + 1'b1;
    assign slot_end = (us_cnt == US_W'(SLOT_LEN - 1));

    // Read slots and write-1 slots share the short low time
    assign slot_low = (state == S_READ || ROM_CMD[bit_cnt[2:0]]) ?
                      US_W'(T_LOW1_US) : US_W'(T_LOW0_US);

    assign dq_oe        = dq_oe_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.error    = error_r;
    assign bus.err_code = err_code_r;
    assign bus.result   = result_r;

    // Prescaler held at zero outside timed states so every phase
    // starts on a whole-microsecond boundary.
    always_ff @(posedge clk) begin
        if (reset || !timed || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dq_m <= 1'b1;
            dq_s <= 1'b1;
        end else begin
            dq_m <= dq_in;
            dq_s <= dq_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            us_cnt     <= '0;
            bit_cnt    <= '0;
            attempt    <= '0;
            presence   <= 1'b0;
            fail_code  <= 2'b00;
            shreg      <= '0;
            dq_oe_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_code_r <= 2'b00;
            result_r   <= '0;
`ifdef ONEWIRE_CRC_CHECK_EN
            crc        <= '0;
`endif
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    dq_oe_r <= 1'b0;
                    // busy is still high on the done/error cycle, so a go
                    // arriving then is dropped here
                    if (busy_r) begin
                        busy_r <= 1'b0;
                    end else if (bus.go) begin
                        err_code_r <= 2'b00;
                        if (!dq_s) begin
                            error_r    <= 1'b1;
                            err_code_r <= 2'b11;
                        end else begin
                            busy_r  <= 1'b1;
                            attempt <= '0;
                            us_cnt  <= '0;
                            dq_oe_r <= 1'b1;
                            state   <= S_RST_LOW;
                        end
                    end
                end

                S_RST_LOW: begin
                    if (tick) begin
                        if (us_cnt == US_W'(T_RSTL_US - 1)) begin
                            us_cnt   <= '0;
                            dq_oe_r  <= 1'b0;
                            presence <= 1'b0;
                            state    <= S_RST_HIGH;
                        end else begin
                            us_cnt <= us_nxt;
                        end
                    end
                end

                S_RST_HIGH: begin
                    if (us_cnt >= PD_MIN &&
                        us_cnt <= US_W'(T_PDMAX_US) && !dq_s) begin
                        presence <= 1'b1;
                    end
                    if (tick) begin
                        if (us_cnt == US_W'(T_RSTH_US - 1)) begin
                            us_cnt <= '0;
                            if (presence) begin
                                bit_cnt <= '0;
                                dq_oe_r <= 1'b1;
                                state   <= S_CMD;
                            end else begin
                                fail_code <= 2'b01;
                                state     <= S_FAIL;
                            end
                        end else begin
                            us_cnt <= us_nxt;
                        end
                    end
                end

                S_CMD, S_READ: begin
                    if (tick) begin
                        if (state == S_READ &&
                            us_cnt == US_W'(T_RDSAMP_US - 1)) begin
                            shreg <= {dq_s, shreg[63:1]};
`ifdef ONEWIRE_CRC_CHECK_EN
                            crc   <= crc_nxt;
`endif
                        end
                        if (slot_end) begin
                            us_cnt  <= '0;
                            bit_cnt <= bit_cnt + 1'b1;
                            dq_oe_r <= 1'b1;
                            if (state == S_CMD && bit_cnt == 6'd7) begin
                                bit_cnt <= '0;
                                state   <= S_READ;
`ifdef ONEWIRE_CRC_CHECK_EN
                                crc     <= '0;
`endif
                            end else if (state == S_READ &&
                                         bit_cnt == 6'd63) begin
                                dq_oe_r <= 1'b0;
                                state   <= S_CHECK;
                            end
                        end else begin
                            us_cnt  <= us_nxt;
                            dq_oe_r <= (us_nxt < slot_low);
                        end
                    end
                end

                S_CHECK: begin
                    dq_oe_r <= 1'b0;
`ifdef ONEWIRE_CRC_CHECK_EN
                    if (crc == 8'h00) begin
                        result_r <= shreg;
                        done_r   <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        fail_code <= 2'b10;
                        state     <= S_FAIL;
                    end
`else
                    result_r <= shreg;
                    done_r   <= 1'b1;
                    state    <= S_IDLE;
`endif
                end

                S_FAIL: begin
                    if (attempt < AW'(N_RETRY)) begin
                        attempt <= attempt + 1'b1;
                        us_cnt  <= '0;
                        dq_oe_r <= 1'b1;
                        state   <= S_RST_LOW;
                    end else begin
                        error_r    <= 1'b1;
                        err_code_r <= fail_code;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    dq_oe_r <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
